align_job_ctrl: RTL and testbench
=================================

Name: align_job_ctrl

Overview:
Job sequencer in front of the DP + traceback top level. It accepts one alignment job at a time and fetches the query (S) and reference (T) bases from a shared sequence memory. It drives the DP load and stream interface, then buffers traceback alignment beats in an output FIFO and acknowledges the DP once the host has drained all results.

Parameters:
BP_WIDTH, 2, bits per base (matches `BP_WIDTH)
LOG_N, 7, log2 of PE count; PE_end width
LEN_WIDTH, 12, width of T length and of the sequence-memory address
FIFO_DEPTH, 16, alignment output buffer depth (power of 2)

Ports:
clk  in  1  clock
reset_i  in  1  synchronous active-high reset
job_valid_i  in  1  job descriptor valid
job_ready_o  out  1  controller idle; job accepted when job_valid_i&&job_ready_o
job_s_len_i  in  LOG_N+1  query length (1..2^LOG_N)
job_t_len_i  in  LEN_WIDTH  reference length (>=1)
seq_rd_en_o  out  1  sequence memory read strobe
seq_rd_sel_o  out  1  0=S bank, 1=T bank
seq_rd_addr_o  out  LEN_WIDTH  read address
seq_rd_data_i  in  BP_WIDTH  read data, valid exactly 1 cycle after seq_rd_en_o
dp_S_o  out  BP_WIDTH  to top.S
dp_s_update_o  out  1  to top.s_update
dp_T_o  out  BP_WIDTH  to top.T
dp_valid_o  out  1  to top.valid
dp_new_seq_o  out  1  to top.new_seq
dp_PE_end_o  out  LOG_N  to top.PE_end
dp_busy_i  in  1  from top.busy; 1 = T beat not accepted this cycle
dp_ack_o  out  1  to top.ack
tb_valid_i  in  1  from top.tb_valid
tb_done_i  in  1  from top.done
aln_data_i  in  BP_WIDTH  from top.alignment_out
aln_valid_i  in  1  from top.alignment_valid
out_data_o  out  BP_WIDTH  FIFO head
out_valid_o  out  1  FIFO non-empty
out_ready_i  in  1  host pop; pop when out_valid_o&&out_ready_i
job_done_o  out  1  1-cycle pulse at job completion
job_err_o  out  1  1-cycle pulse with job_done_o on an illegal descriptor
overflow_o  out  1  sticky; alignment beat lost because the FIFO was full

Behaviour:
- Reset (synchronous, any state): state=IDLE, FIFO emptied, counters=0, overflow_o=0. All outputs 0 except job_ready_o=1.
- States: IDLE, LOAD_S, STREAM_T, WAIT_TB, CAPTURE, DRAIN, ACK.
- IDLE: job_ready_o=1. On accept, latch the lengths and clear overflow_o. PE_end register = s_len-1, held until the next accept.
- Illegal job: s_len==0, s_len>2^LOG_N, or t_len==0. The next cycle pulses job_done_o and job_err_o, then returns to IDLE. No memory or DP activity.
- Legal job: enter LOAD_S. dp_new_seq_o pulses in the first LOAD_S cycle.
- LOAD_S: one S read per cycle, sel=0, addr 0..s_len-1. Each returned base appears on dp_S_o with dp_s_update_o=1 the cycle after its read, so there are exactly s_len update cycles and they are back-to-back.
- STREAM_T: enter after the last S beat. Reads use sel=1, addr 0..t_len-1.
  - A one-entry skid register holds the returned base; dp_valid_o=1 while it is occupied.
  - A beat transfers when dp_valid_o&&!dp_busy_i.
  - A new read issues only if the skid register is empty or transferring this cycle. Back-to-back when busy=0, so t_len beats take t_len+1 cycles.
  - dp_T_o holds stable while valid&&busy.
- WAIT_TB: entered after the last T transfer. Leave for CAPTURE when tb_valid_i=1.
- CAPTURE: each aln_valid_i pushes aln_data_i.
  - Push while full drops the beat and sets overflow_o.
  - Simultaneous push and pop on a full FIFO is legal: no drop.
  - tb_done_i moves the state to DRAIN. A beat with aln_valid_i in the same cycle is still captured.
- DRAIN: wait for the FIFO to be empty, then go to ACK.
- ACK: dp_ack_o=1 and job_done_o=1 for one cycle, then IDLE.
- The FIFO pops in every state. It keeps first-word-fall-through ordering and has 0-cycle out_valid_o latency after a push.
- job_valid_i outside IDLE is ignored.
- aln_valid_i outside CAPTURE is ignored.

Test Plan:
- s_len=4, t_len=6, busy=0: S addrs 0..3 with 4 consecutive s_update cycles; new_seq pulses once; PE_end=3; 6 back-to-back T beats matching memory contents.
- dp_busy_i high for 3 cycles mid-stream: dp_T_o and dp_valid_o hold; no beat duplicated or lost; at most 1 outstanding read.
- Traceback emits 10 beats, host ready=1: out_data_o order matches; one dp_ack_o and one job_done_o pulse after the last pop.
- 20 beats with out_ready_i=0: 16 stored, overflow_o=1; after the drain, job_done_o fires; overflow_o clears on the next accept.
- s_len=0, then s_len=129 (LOG_N=7), then t_len=0: each gives job_done_o+job_err_o 1 cycle after accept and no seq_rd_en_o.
- reset_i asserted during STREAM_T: next cycle all strobes are 0, job_ready_o=1, FIFO is empty, and a following job runs correctly.

Source files
------------

// File: rtl/align_job_ctrl.sv
// Job sequencer: fetches S/T bases from sequence memory, streams them to the DP array,
// then buffers traceback beats in an output FIFO and acks the DP once the host has drained them.

module align_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_dat,
   output logic         o_vld,
   output logic         o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_cnt;
   logic          w_wr;
   logic          w_rd;

   assign o_vld  = (r_cnt != '0);
   assign o_full = (r_cnt == (AW+1)'(DEPTH));
   assign w_rd   = i_pop && o_vld;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign w_wr   = i_push && (!o_full || w_rd);
   assign o_dat  = o_vld ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_dat;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

module align_job_ctrl #(
   parameter int BP_WIDTH   = 2,
   parameter int LOG_N      = 7,
   parameter int LEN_WIDTH  = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic                 job_valid_i,
   output logic                 job_ready_o,
   input  logic [LOG_N:0]       job_s_len_i,
   input  logic [LEN_WIDTH-1:0] job_t_len_i,
   output logic                 seq_rd_en_o,
   output logic                 seq_rd_sel_o,
   output logic [LEN_WIDTH-1:0] seq_rd_addr_o,
   input  logic [BP_WIDTH-1:0]  seq_rd_data_i,
   output logic [BP_WIDTH-1:0]  dp_S_o,
   output logic                 dp_s_update_o,
   output logic [BP_WIDTH-1:0]  dp_T_o,
   output logic                 dp_valid_o,
   output logic                 dp_new_seq_o,
   output logic [LOG_N-1:0]     dp_PE_end_o,
   input  logic                 dp_busy_i,
   output logic                 dp_ack_o,
   input  logic                 tb_valid_i,
   input  logic                 tb_done_i,
   input  logic [BP_WIDTH-1:0]  aln_data_i,
   input  logic                 aln_valid_i,
   output logic [BP_WIDTH-1:0]  out_data_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 job_done_o,
   output logic                 job_err_o,
   output logic                 overflow_o
);
   localparam int CW = LEN_WIDTH + 1;
   localparam logic [LOG_N:0] S_MAX = {1'b1, {LOG_N{1'b0}}};

   typedef enum logic [2:0] {IDLE, LOAD_S, STREAM_T, WAIT_TB, CAPTURE, DRAIN, ACK} state_t;

   state_t                r_state;
   logic [LOG_N:0]        r_s_len;
   logic [LEN_WIDTH-1:0]  r_t_len;
   logic [CW-1:0]         r_cnt;
   logic [LOG_N-1:0]      r_pe_end;
   logic                  r_new_seq;
   logic                  r_s_upd;
   logic                  r_t_occ;
   logic                  r_t_fresh;
   logic [BP_WIDTH-1:0]   r_t_hold;
   logic                  r_ack;
   logic                  r_done;
   logic                  r_err;
   logic                  r_ovf;

   logic                  w_legal;
   logic [LOG_N:0]        w_s_len_m1;
   logic                  w_s_rd;
   logic                  w_t_rd;
   logic                  w_t_xfer;
   logic                  w_push;
   logic                  w_full;
   logic                  w_drop;

   assign w_legal    = (job_s_len_i != '0) && (job_s_len_i <= S_MAX) && (job_t_len_i != '0);
   assign w_s_len_m1 = job_s_len_i - (LOG_N+1)'(1);

   assign w_s_rd   = (r_state == LOAD_S) && (r_cnt < CW'(r_s_len));
   assign w_t_xfer = r_t_occ && !dp_busy_i;
   // One-entry skid: only refill when the held beat is empty or leaving this cycle.
   assign w_t_rd   = (r_state == STREAM_T) && (r_cnt < CW'(r_t_len)) && (!r_t_occ || !dp_busy_i);

   assign seq_rd_en_o   = w_s_rd || w_t_rd;
   assign seq_rd_sel_o  = w_t_rd;
   assign seq_rd_addr_o = (w_s_rd || w_t_rd) ? r_cnt[LEN_WIDTH-1:0] : '0;

   assign dp_S_o        = r_s_upd ? seq_rd_data_i : '0;
   assign dp_s_update_o = r_s_upd;
   // Fresh read data is forwarded straight from memory; a stalled beat comes from the hold register.
   assign dp_T_o        = !r_t_occ ? '0 : (r_t_fresh ? seq_rd_data_i : r_t_hold);
   assign dp_valid_o    = r_t_occ;
   assign dp_new_seq_o  = r_new_seq;
   assign dp_PE_end_o   = r_pe_end;
   assign dp_ack_o      = r_ack;
   assign job_ready_o   = (r_state == IDLE);
   assign job_done_o    = r_done;
   assign job_err_o     = r_err;
   assign overflow_o    = r_ovf;

   assign w_push = (r_state == CAPTURE) && aln_valid_i;
   assign w_drop = w_push && w_full && !(out_ready_i && out_valid_o);

   align_fifo #(.W(BP_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (clk),
      .i_reset (reset_i),
      .i_push  (w_push),
      .i_dat   (aln_data_i),
      .i_pop   (out_ready_i),
      .o_dat   (out_data_o),
      .o_vld   (out_valid_o),
      .o_full  (w_full)
   );

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state   <= IDLE;
         r_s_len   <= '0;
         r_t_len   <= '0;
         r_cnt     <= '0;
         r_pe_end  <= '0;
         r_new_seq <= 1'b0;
         r_s_upd   <= 1'b0;
         r_t_occ   <= 1'b0;
         r_t_fresh <= 1'b0;
         r_t_hold  <= '0;
         r_ack     <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_new_seq <= 1'b0;
         r_s_upd   <= w_s_rd;
         r_t_fresh <= w_t_rd;
         r_t_occ   <= w_t_rd || (r_t_occ && !w_t_xfer);
         if (r_t_fresh) r_t_hold <= seq_rd_data_i;
         if (w_drop) r_ovf <= 1'b1;

         case (r_state)
            IDLE: begin
               if (job_valid_i) begin
                  r_s_len  <= job_s_len_i;
                  r_t_len  <= job_t_len_i;
                  r_pe_end <= w_s_len_m1[LOG_N-1:0];
                  r_cnt    <= '0;
                  r_ovf    <= 1'b0;
                  if (w_legal) begin
                     r_state   <= LOAD_S;
                     r_new_seq <= 1'b1;
                  end else begin
                     r_state <= ACK;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end
               end
            end
            LOAD_S: begin
               // The extra cycle after the last read carries the final S beat.
               if (w_s_rd) begin
                  r_cnt <= r_cnt + CW'(1);
               end else begin
                  r_cnt   <= '0;
                  r_state <= STREAM_T;
               end
            end
            STREAM_T: begin
               if (w_t_rd) r_cnt <= r_cnt + CW'(1);
               if ((r_cnt == CW'(r_t_len)) && w_t_xfer) r_state <= WAIT_TB;
            end
            WAIT_TB: begin
               if (tb_valid_i) r_state <= CAPTURE;
            end
            CAPTURE: begin
               if (tb_done_i) r_state <= DRAIN;
            end
            DRAIN: begin
               if (!out_valid_o) begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
                  r_done  <= 1'b1;
               end
            end
            ACK: begin
               r_state <= IDLE;
               r_ack   <= 1'b0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_align_job_ctrl.sv
// Bench for align_job_ctrl: random memory contents and traceback beats, checked against
// queue-based expectations derived from job lengths and FIFO capacity.

module tb_align_job_ctrl;
   localparam int BPW  = 2;
   localparam int LOGN = 7;
   localparam int LENW = 12;
   localparam int FD   = 16;

   logic            clk = 1'b0;
   logic            reset_i = 1'b0;
   logic            job_valid_i = 1'b0;
   logic            job_ready_o;
   logic [LOGN:0]   job_s_len_i = '0;
   logic [LENW-1:0] job_t_len_i = '0;
   logic            seq_rd_en_o;
   logic            seq_rd_sel_o;
   logic [LENW-1:0] seq_rd_addr_o;
   logic [BPW-1:0]  seq_rd_data_i = '0;
   logic [BPW-1:0]  dp_S_o;
   logic            dp_s_update_o;
   logic [BPW-1:0]  dp_T_o;
   logic            dp_valid_o;
   logic            dp_new_seq_o;
   logic [LOGN-1:0] dp_PE_end_o;
   logic            dp_busy_i = 1'b0;
   logic            dp_ack_o;
   logic            tb_valid_i = 1'b0;
   logic            tb_done_i = 1'b0;
   logic [BPW-1:0]  aln_data_i = '0;
   logic            aln_valid_i = 1'b0;
   logic [BPW-1:0]  out_data_o;
   logic            out_valid_o;
   logic            out_ready_i = 1'b1;
   logic            job_done_o;
   logic            job_err_o;
   logic            overflow_o;

   always #5 clk = ~clk;

   align_job_ctrl #(.BP_WIDTH(BPW), .LOG_N(LOGN), .LEN_WIDTH(LENW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset_i(reset_i),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
      .job_s_len_i(job_s_len_i), .job_t_len_i(job_t_len_i),
      .seq_rd_en_o(seq_rd_en_o), .seq_rd_sel_o(seq_rd_sel_o),
      .seq_rd_addr_o(seq_rd_addr_o), .seq_rd_data_i(seq_rd_data_i),
      .dp_S_o(dp_S_o), .dp_s_update_o(dp_s_update_o), .dp_T_o(dp_T_o),
      .dp_valid_o(dp_valid_o), .dp_new_seq_o(dp_new_seq_o), .dp_PE_end_o(dp_PE_end_o),
      .dp_busy_i(dp_busy_i), .dp_ack_o(dp_ack_o),
      .tb_valid_i(tb_valid_i), .tb_done_i(tb_done_i),
      .aln_data_i(aln_data_i), .aln_valid_i(aln_valid_i),
      .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .job_done_o(job_done_o), .job_err_o(job_err_o), .overflow_o(overflow_o)
   );

   // Sequence memory: data valid exactly one cycle after the read strobe, garbage otherwise.
   logic [BPW-1:0] s_mem [128];
   logic [BPW-1:0] t_mem [4096];
   always @(posedge clk)
      seq_rd_data_i <= seq_rd_en_o ? (seq_rd_sel_o ? t_mem[seq_rd_addr_o] : s_mem[seq_rd_addr_o[6:0]])
                                   : BPW'($urandom);

   logic [BPW-1:0] s_q[$], t_q[$], pop_q[$], exp_q[$];
   int rd_cnt, newseq_cnt, ack_cnt, done_cnt, err_cnt, viol_cnt, pop_at_done;
   logic prev_vb, s_seen, s_ended;
   logic [BPW-1:0] prev_t;

   always @(negedge clk) begin
      if (reset_i) begin
         prev_vb = 1'b0;
      end else begin
         if (seq_rd_en_o) rd_cnt++;
         if (dp_new_seq_o) newseq_cnt++;
         if (dp_ack_o) ack_cnt++;
         if (job_err_o) err_cnt++;
         if (dp_s_update_o) begin
            if (s_ended) viol_cnt++;
            s_q.push_back(dp_S_o);
            s_seen = 1'b1;
         end else if (s_seen) s_ended = 1'b1;
         if (prev_vb && !(dp_valid_o && dp_T_o === prev_t)) viol_cnt++;
         if (dp_valid_o && dp_busy_i && seq_rd_en_o) viol_cnt++;
         if (dp_valid_o && !dp_busy_i) t_q.push_back(dp_T_o);
         prev_vb = dp_valid_o && dp_busy_i;
         prev_t  = dp_T_o;
         if (out_valid_o && out_ready_i) pop_q.push_back(out_data_o);
         if (job_done_o) begin
            if (done_cnt == 0) pop_at_done = pop_q.size();
            done_cnt++;
         end
      end
   end

   // Busy: 0 never, 1 random, 2 one 3-cycle burst mid-stream. Ready: 0 always, 1 random, 2 stuck low.
   int busy_mode = 0, ready_mode = 0, burst_left = 0;
   logic burst_done = 1'b0;
   always @(posedge clk) begin
      #1;
      if (busy_mode == 2 && !burst_done && t_q.size() == 2) begin
         burst_left = 3;
         burst_done = 1'b1;
      end
      if (busy_mode == 1)      dp_busy_i = ($urandom_range(0, 2) == 0);
      else if (burst_left > 0) begin dp_busy_i = 1'b1; burst_left--; end
      else                     dp_busy_i = 1'b0;
      if (ready_mode == 1)      out_ready_i = ($urandom_range(0, 1) == 1);
      else                      out_ready_i = (ready_mode == 0);
   end

   int n_total = 0, n_pass = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      s_q.delete(); t_q.delete(); pop_q.delete(); exp_q.delete();
      rd_cnt = 0; newseq_cnt = 0; ack_cnt = 0; done_cnt = 0; err_cnt = 0;
      viol_cnt = 0; pop_at_done = -1; s_seen = 1'b0; s_ended = 1'b0;
      burst_done = 1'b0; burst_left = 0;
      for (int i = 0; i < 128; i++)  s_mem[i] = BPW'($urandom);
      for (int i = 0; i < 4096; i++) t_mem[i] = BPW'($urandom);
   endtask

   task automatic accept(input int sl, input int tl);
      int k = 0;
      while (!job_ready_o && k < 500) begin @(posedge clk); #1; k++; end
      chk("ready_before_job", job_ready_o, 1);
      job_valid_i = 1'b1;
      job_s_len_i = (LOGN+1)'(sl);
      job_t_len_i = LENW'(tl);
      @(posedge clk); #1;
      job_valid_i = 1'b0;
      job_s_len_i = (LOGN+1)'($urandom);
      job_t_len_i = LENW'($urandom);
   endtask

   task automatic wait_t(input int tl);
      int k = 0;
      while (t_q.size() < tl && k < 5000) begin @(posedge clk); #1; k++; end
      chk("t_beats_count", t_q.size(), tl);
   endtask

   task automatic run_job(input int sl, input int tl, input int na, input int bm, input int rm);
      int k, mis;
      logic [BPW-1:0] d;
      clear_mon();
      busy_mode = bm;
      ready_mode = rm;
      accept(sl, tl);
      chk("ovf_clear_on_accept", overflow_o, 0);
      wait_t(tl);
      tb_valid_i = 1'b1;
      @(posedge clk); #1;
      tb_valid_i = 1'b0;
      for (int i = 0; i < na; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         d = BPW'($urandom);
         aln_valid_i = 1'b1;
         aln_data_i  = d;
         tb_done_i   = (i == na - 1);
         if (rm != 2 || i < FD) exp_q.push_back(d);
         @(posedge clk); #1;
         aln_valid_i = 1'b0;
         tb_done_i   = 1'b0;
      end
      if (rm == 2) begin
         chk("ovf_set_when_full", overflow_o, (na > FD) ? 1 : 0);
         chk("fifo_holds_beats", out_valid_o, 1);
         ready_mode = 0;
      end
      k = 0;
      while (done_cnt == 0 && k < 2000) begin @(posedge clk); #1; k++; end
      repeat (4) begin @(posedge clk); #1; end
      chk("job_done_pulses", done_cnt, 1);
      chk("dp_ack_pulses", ack_cnt, 1);
      chk("job_err_pulses", err_cnt, 0);
      chk("new_seq_pulses", newseq_cnt, 1);
      chk("mem_reads", rd_cnt, sl + tl);
      chk("pe_end", dp_PE_end_o, sl - 1);
      chk("stream_rule_viol", viol_cnt, 0);
      chk("s_beats_count", s_q.size(), sl);
      mis = 0;
      for (int i = 0; i < s_q.size() && i < sl; i++) if (s_q[i] !== s_mem[i]) mis++;
      chk("s_beats_data", mis, 0);
      mis = 0;
      for (int i = 0; i < t_q.size() && i < tl; i++) if (t_q[i] !== t_mem[i]) mis++;
      chk("t_beats_data", mis, 0);
      chk("pops_count", pop_q.size(), exp_q.size());
      mis = 0;
      for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++) if (pop_q[i] !== exp_q[i]) mis++;
      chk("pops_data", mis, 0);
      chk("pops_before_done", pop_at_done, exp_q.size());
      chk("overflow_sticky", overflow_o, (rm == 2 && na > FD) ? 1 : 0);
      chk("idle_after_job", {job_ready_o, out_valid_o, dp_valid_o}, 3'b100);
      busy_mode = 0;
      ready_mode = 0;
   endtask

   task automatic run_bad(input int sl, input int tl);
      clear_mon();
      accept(sl, tl);
      chk("bad_done_err_pulse", {job_done_o, job_err_o, job_ready_o, dp_ack_o}, 4'b1100);
      @(posedge clk); #1;
      chk("bad_back_idle", {job_done_o, job_err_o, job_ready_o}, 3'b001);
      repeat (2) begin @(posedge clk); #1; end
      chk("bad_no_activity", {rd_cnt[15:0], newseq_cnt[7:0], ack_cnt[7:0]}, 0);
   endtask

   initial begin
      reset_i = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("reset_outputs",
          {seq_rd_en_o, dp_valid_o, dp_s_update_o, dp_new_seq_o, dp_ack_o,
           job_done_o, job_err_o, out_valid_o, overflow_o, job_ready_o}, 10'b0000000001);
      chk("reset_values", {dp_PE_end_o, dp_T_o, dp_S_o, out_data_o, seq_rd_addr_o}, 0);
      reset_i = 1'b0;
      @(posedge clk); #1;

      run_job(4, 6, 10, 0, 0);
      run_job(8, 20, 12, 2, 1);
      run_job(16, 8, 20, 0, 2);
      run_job(3, 5, 6, 1, 0);
      run_bad(0, 5);
      run_bad(129, 5);
      run_bad(10, 0);
      run_job(128, 10, 16, 1, 1);
      run_job(1, 1, 1, 0, 0);

      // Reset in the middle of T streaming.
      clear_mon();
      busy_mode = 1;
      accept(8, 60);
      begin
         int k = 0;
         while (t_q.size() < 5 && k < 1000) begin @(posedge clk); #1; k++; end
      end
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      chk("mid_reset_outputs",
          {seq_rd_en_o, dp_valid_o, dp_s_update_o, dp_new_seq_o, dp_ack_o,
           job_done_o, job_err_o, out_valid_o, overflow_o, job_ready_o}, 10'b0000000001);
      busy_mode = 0;
      run_job(5, 9, 7, 1, 1);

      for (int r = 0; r < 3; r++)
         run_job($urandom_range(1, 128), $urandom_range(1, 40), $urandom_range(1, 16),
                 $urandom_range(0, 1), $urandom_range(0, 1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
